// File: rtl/vc_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_alloc_pkg
//  Purpose  : Shared sizes, row FSM encoding and flat-bus helpers for the
//             second-stage VC allocator.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vc_alloc_pkg;

  localparam int N_PORT = 5;
  localparam int N_VC   = 4;
  localparam int N_TOT  = N_PORT * N_VC;
  localparam int PTR_W  = $clog2(N_TOT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } row_state_e;

  // Row j of a flat N_TOT x N_TOT bus.
  function automatic logic [N_TOT-1:0] row_of(input logic [N_TOT*N_TOT-1:0] flat,
                                               input int unsigned             j);
    return flat[j*N_TOT +: N_TOT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_out_arbiter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : vc_out_arbiter_bank_if
//  Purpose  : Request/release/grant bundle between the request transpose and
//             the per-output-VC arbiter bank.
//  Signals  : req_i     N_TOT*N_TOT  row j = requesters of output VC j
//             release_i N_TOT        bit j frees output VC j
//             grant_o   N_TOT*N_TOT  row j = one-hot winner, one-cycle pulse
//             busy_o    N_TOT        bit j = output VC j allocated
//  Revision : 1.0 - initial release
// ============================================================================
interface vc_out_arbiter_bank_if;

  logic [vc_alloc_pkg::N_TOT*vc_alloc_pkg::N_TOT-1:0] req_i;
  logic [vc_alloc_pkg::N_TOT-1:0]                     release_i;
  logic [vc_alloc_pkg::N_TOT*vc_alloc_pkg::N_TOT-1:0] grant_o;
  logic [vc_alloc_pkg::N_TOT-1:0]                     busy_o;

  // Upstream / environment side.
  modport master (
    output req_i,
    output release_i,
    input  grant_o,
    input  busy_o
  );

  // Arbiter bank side.
  modport slave (
    input  req_i,
    input  release_i,
    output grant_o,
    output busy_o
  );

endinterface
`default_nettype wire

// File: rtl/vc_out_arbiter_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : N_TOT-wide round-robin arbiter. Combinational one-hot grant of
//             the first requester at or above the pointer (wrapping); the
//             pointer moves past the winner only when enabled with a grant.
//  Ports    : clk, rstn (sync, active-low), req, enable, grant, grant_valid
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import vc_alloc_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic [N_TOT-1:0] req,
  input  wire logic             enable,
  output logic      [N_TOT-1:0] grant,
  output logic                  grant_valid
);

  localparam logic [PTR_W:0]   C_N_TOT = (PTR_W+1)'(N_TOT);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(N_TOT - 1);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W:0]   w_idx;

  // Scan offsets from highest to lowest so the smallest offset from the
  // pointer is the last assignment and therefore wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_win       = '0;
    w_idx       = '0;
    for (int k = N_TOT - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= C_N_TOT) begin
        w_idx = w_idx - C_N_TOT;
      end
      if (req[w_idx[PTR_W-1:0]]) begin
        w_win       = w_idx[PTR_W-1:0];
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) begin
      grant[w_win] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_win == C_LAST) ? '0 : w_win + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (enable && grant_valid) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_out_arbiter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vc_out_arbiter_bank
//  Purpose  : Second stage of the separable VC allocator. One round-robin
//             arbiter and IDLE/ALLOC state per output VC; a granted output VC
//             stays allocated until its release pulse.
//  Ports    : clk   clock
//             rstn  synchronous active-low reset
//             bus   vc_out_arbiter_bank_if.slave (req_i, release_i,
//                   grant_o registered one-hot pulse, busy_o registered)
//  Revision : 1.0 - initial release
// ============================================================================
module vc_out_arbiter_bank
  import vc_alloc_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rstn,
  vc_out_arbiter_bank_if.slave bus
);

  logic [N_TOT*N_TOT-1:0] w_grant_flat;
  logic [N_TOT-1:0]       w_busy;

  for (genvar j = 0; j < N_TOT; j++) begin : g_row
    row_state_e       r_state;
    row_state_e       w_state_nxt;
    logic [N_TOT-1:0] r_grant;
    logic [N_TOT-1:0] w_req;
    logic [N_TOT-1:0] w_arb_grant;
    logic             w_arb_valid;
    logic             w_idle;

    assign w_req  = row_of(bus.req_i, j);
    assign w_idle = (r_state == IDLE);

    // Pointer only moves when this row actually takes a grant, i.e. in IDLE.
    rr_arbiter u_arb (
      .clk         (clk),
      .rstn        (rstn),
      .req         (w_req),
      .enable      (w_idle),
      .grant       (w_arb_grant),
      .grant_valid (w_arb_valid)
    );

    // A release arriving together with a request only returns the row to
    // IDLE; the request is arbitrated on the following cycle.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        IDLE:    if (w_arb_valid)       w_state_nxt = ALLOC;
        ALLOC:   if (bus.release_i[j])  w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_state <= IDLE;
        r_grant <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_grant <= (w_idle && w_arb_valid) ? w_arb_grant : '0;
      end
    end

    assign w_grant_flat[j*N_TOT +: N_TOT] = r_grant;
    assign w_busy[j]                      = (r_state == ALLOC);
  end

  assign bus.grant_o = w_grant_flat;
  assign bus.busy_o  = w_busy;

endmodule
`default_nettype wire
